// File: rtl/wb_reorder_buffer_pkg.sv
// Shared types and sizing helpers for the writeback reorder buffer.
// Provides the XLEN-wide exception record carried alongside each result.
package wb_reorder_buffer_pkg;

    localparam int XLEN                = 64;
    localparam int NR_ENTRIES_DEFAULT  = 8;
    localparam int NR_WB_PORTS_DEFAULT = 5;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    function automatic int trans_id_bits(input int nr_entries);
        return $clog2(nr_entries);
    endfunction

    function automatic int port_sel_bits(input int nr_ports);
        return (nr_ports > 1) ? $clog2(nr_ports) : 1;
    endfunction

endpackage

// File: rtl/wb_reorder_buffer_if.sv
// Issue, writeback and commit signal bundle of the reorder buffer.
// The master side is issue/execute/commit; the slave side is the buffer itself.
interface wb_reorder_buffer_if
    import wb_reorder_buffer_pkg::*;
#(
    parameter int NR_ENTRIES  = NR_ENTRIES_DEFAULT,
    parameter int NR_WB_PORTS = NR_WB_PORTS_DEFAULT
) ();

    localparam int TRANS_ID_BITS = trans_id_bits(NR_ENTRIES);

    logic                                         issue_valid_i;
    logic                                         issue_ready_o;
    logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o;

    logic [NR_WB_PORTS-1:0]                       wb_valid_i;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][XLEN-1:0]             wb_result_i;
    exception_t [NR_WB_PORTS-1:0]                 wb_exception_i;

    logic                                         commit_valid_o;
    logic                                         commit_ack_i;
    logic [TRANS_ID_BITS-1:0]                     commit_trans_id_o;
    logic [XLEN-1:0]                              commit_result_o;
    exception_t                                   commit_exception_o;

    modport master (
        output issue_valid_i,
        input  issue_ready_o,
        input  issue_trans_id_o,
        output wb_valid_i,
        output wb_trans_id_i,
        output wb_result_i,
        output wb_exception_i,
        input  commit_valid_o,
        output commit_ack_i,
        input  commit_trans_id_o,
        input  commit_result_o,
        input  commit_exception_o
    );

    modport slave (
        input  issue_valid_i,
        output issue_ready_o,
        output issue_trans_id_o,
        input  wb_valid_i,
        input  wb_trans_id_i,
        input  wb_result_i,
        input  wb_exception_i,
        output commit_valid_o,
        input  commit_ack_i,
        output commit_trans_id_o,
        output commit_result_o,
        output commit_exception_o
    );

endinterface

// File: rtl/wb_reorder_buffer_port_select.sv
// Per-entry priority select over the writeback ports: the lowest-index port
// targeting ENTRY_ID wins, and a second hit raises multi_hit_o.
module wb_reorder_buffer_port_select
    import wb_reorder_buffer_pkg::*;
#(
    parameter int NR_WB_PORTS   = NR_WB_PORTS_DEFAULT,
    parameter int TRANS_ID_BITS = 3,
    parameter int ENTRY_ID      = 0
) (
    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
    output logic                                      hit_o,
    output logic                                      multi_hit_o,
    output logic [port_sel_bits(NR_WB_PORTS)-1:0]     sel_o
);

    localparam int PORT_BITS = port_sel_bits(NR_WB_PORTS);
    localparam logic [TRANS_ID_BITS-1:0] MY_ID = TRANS_ID_BITS'(ENTRY_ID);

    always_comb begin
        hit_o       = 1'b0;
        multi_hit_o = 1'b0;
        sel_o       = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && (wb_trans_id_i[p] == MY_ID)) begin
                if (hit_o) begin
                    multi_hit_o = 1'b1;
                end else begin
                    hit_o = 1'b1;
                    sel_o = PORT_BITS'(p);
                end
            end
        end
    end

endmodule

// File: rtl/wb_reorder_buffer.sv
// Reorder buffer: allocates transaction IDs at issue, collects out-of-order
// writebacks and hands results/exceptions to commit strictly in issue order.
module wb_reorder_buffer
    import wb_reorder_buffer_pkg::*;
#(
    parameter int NR_ENTRIES  = NR_ENTRIES_DEFAULT,
    parameter int NR_WB_PORTS = NR_WB_PORTS_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    wb_reorder_buffer_if.slave        rob,
    output logic                      empty_o,
    output logic                      wb_err_o
);

    localparam int TRANS_ID_BITS = trans_id_bits(NR_ENTRIES);
    localparam int PTR_BITS      = TRANS_ID_BITS + 1;
    localparam int PORT_BITS     = port_sel_bits(NR_WB_PORTS);

    typedef enum logic [1:0] {
        ENTRY_FREE,
        ENTRY_ISSUED,
        ENTRY_DONE
    } entry_state_e;

    entry_state_e              state_q     [NR_ENTRIES];
    entry_state_e              state_d     [NR_ENTRIES];
    logic [XLEN-1:0]           result_q    [NR_ENTRIES];
    logic [XLEN-1:0]           result_d    [NR_ENTRIES];
    exception_t                exception_q [NR_ENTRIES];
    exception_t                exception_d [NR_ENTRIES];
    logic [PTR_BITS-1:0]       head_q, head_d;
    logic [PTR_BITS-1:0]       tail_q, tail_d;
    logic                      wb_err_q, wb_err_d;

    logic [TRANS_ID_BITS-1:0]  head_idx;
    logic [TRANS_ID_BITS-1:0]  tail_idx;
    logic                      full;
    logic                      empty;
    logic                      issue_fire;
    logic                      commit_fire;

    logic [NR_ENTRIES-1:0]     entry_hit;
    logic [NR_ENTRIES-1:0]     entry_multi_hit;
    logic [PORT_BITS-1:0]      entry_sel   [NR_ENTRIES];

    assign head_idx = head_q[TRANS_ID_BITS-1:0];
    assign tail_idx = tail_q[TRANS_ID_BITS-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TRANS_ID_BITS] != tail_q[TRANS_ID_BITS]);
    assign empty    = (head_q == tail_q);

    // Ready is derived from the registered pointers only, so a same-cycle ack
    // cannot open a slot for a same-cycle issue.
    assign issue_fire  = rob.issue_valid_i && !full;
    assign commit_fire = rob.commit_ack_i && (state_q[head_idx] == ENTRY_DONE);

    for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_port_select
        wb_reorder_buffer_port_select #(
            .NR_WB_PORTS   (NR_WB_PORTS),
            .TRANS_ID_BITS (TRANS_ID_BITS),
            .ENTRY_ID      (e)
        ) u_port_select (
            .wb_valid_i    (rob.wb_valid_i),
            .wb_trans_id_i (rob.wb_trans_id_i),
            .hit_o         (entry_hit[e]),
            .multi_hit_o   (entry_multi_hit[e]),
            .sel_o         (entry_sel[e])
        );
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        exception_d = exception_q;
        head_d      = head_q;
        tail_d      = tail_q;
        wb_err_d    = wb_err_q;

        if (flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                state_d[e]     = ENTRY_FREE;
                result_d[e]    = '0;
                exception_d[e] = '0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (entry_hit[e] && (state_q[e] == ENTRY_ISSUED)) begin
                    state_d[e]     = ENTRY_DONE;
                    result_d[e]    = rob.wb_result_i[entry_sel[e]];
                    exception_d[e] = rob.wb_exception_i[entry_sel[e]];
                end
                if (entry_multi_hit[e]) begin
                    wb_err_d = 1'b1;
                end
            end
            // A writeback aimed at an entry that is not waiting for one is dropped.
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (rob.wb_valid_i[p] && (state_q[rob.wb_trans_id_i[p]] != ENTRY_ISSUED)) begin
                    wb_err_d = 1'b1;
                end
            end

            if (commit_fire) begin
                state_d[head_idx] = ENTRY_FREE;
                head_d            = head_q + PTR_BITS'(1);
            end

            if (issue_fire) begin
                state_d[tail_idx]     = ENTRY_ISSUED;
                result_d[tail_idx]    = '0;
                exception_d[tail_idx] = '0;
                tail_d                = tail_q + PTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                state_q[e]     <= ENTRY_FREE;
                result_q[e]    <= '0;
                exception_q[e] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            exception_q <= exception_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign rob.issue_ready_o      = !full;
    assign rob.issue_trans_id_o   = tail_idx;
    assign rob.commit_valid_o     = (state_q[head_idx] == ENTRY_DONE);
    assign rob.commit_trans_id_o  = head_idx;
    assign rob.commit_result_o    = result_q[head_idx];
    assign rob.commit_exception_o = exception_q[head_idx];
    assign empty_o                = empty;
    assign wb_err_o               = wb_err_q;

endmodule

// File: tb/tb_wb_reorder_buffer.sv
// Directed bench for wb_reorder_buffer: allocation, out-of-order writeback,
// in-order commit, wrap, port conflicts, illegal writebacks, flush and reset.
module tb_wb_reorder_buffer;
    import wb_reorder_buffer_pkg::*;

    localparam int NR_ENTRIES  = 8;
    localparam int NR_WB_PORTS = 5;
    localparam int TID_BITS    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic empty;
    logic wb_err;

    int error_count = 0;
    int check_count = 0;

    wb_reorder_buffer_if #(.NR_ENTRIES(NR_ENTRIES), .NR_WB_PORTS(NR_WB_PORTS)) rob_if ();

    wb_reorder_buffer #(.NR_ENTRIES(NR_ENTRIES), .NR_WB_PORTS(NR_WB_PORTS)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .rob      (rob_if.slave),
        .empty_o  (empty),
        .wb_err_o (wb_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearInputs();
        flush                 = 1'b0;
        rob_if.issue_valid_i  = 1'b0;
        rob_if.commit_ack_i   = 1'b0;
        rob_if.wb_valid_i     = '0;
        rob_if.wb_trans_id_i  = '0;
        rob_if.wb_result_i    = '0;
        rob_if.wb_exception_i = '0;
    endtask

    task automatic clearWriteback();
        rob_if.wb_valid_i     = '0;
        rob_if.wb_trans_id_i  = '0;
        rob_if.wb_result_i    = '0;
        rob_if.wb_exception_i = '0;
    endtask

    // One clock edge with the currently driven inputs; outputs settle 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic driveWriteback(input int port, input logic [TID_BITS-1:0] id,
                                  input logic [63:0] value, input logic exc_valid,
                                  input logic [63:0] cause);
        exception_t exc;
        exc.cause = cause;
        exc.tval  = 64'h0;
        exc.valid = exc_valid;
        rob_if.wb_valid_i[port]     = 1'b1;
        rob_if.wb_trans_id_i[port]  = id;
        rob_if.wb_result_i[port]    = value;
        rob_if.wb_exception_i[port] = exc;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},  rob_if.issue_ready_o, 1'b1);
        checkOutput({tag, "_id"},     rob_if.issue_trans_id_o, 0);
        checkOutput({tag, "_empty"},  empty, 1'b1);
        checkOutput({tag, "_cvalid"}, rob_if.commit_valid_o, 1'b0);
        checkOutput({tag, "_cres"},   rob_if.commit_result_o, 0);
        checkOutput({tag, "_cexc"},   |rob_if.commit_exception_o, 1'b0);
        checkOutput({tag, "_err"},    wb_err, 1'b0);
    endtask

    initial begin
        clearInputs();
        #3;
        checkResetValues("reset");
        #9 rst_n = 1'b1;

        // Fill all eight entries back to back.
        for (int i = 0; i < NR_ENTRIES; i++) begin
            checkOutput("fill_id", rob_if.issue_trans_id_o, i);
            checkOutput("fill_ready", rob_if.issue_ready_o, 1'b1);
            rob_if.issue_valid_i = 1'b1;
            applyStimulus();
        end
        rob_if.issue_valid_i = 1'b0;
        checkOutput("full_ready", rob_if.issue_ready_o, 1'b0);
        checkOutput("full_empty", empty, 1'b0);
        checkOutput("full_id", rob_if.issue_trans_id_o, 0);
        checkOutput("full_cvalid", rob_if.commit_valid_o, 1'b0);

        // Full: ack the head together with an issue; the issue waits a cycle.
        driveWriteback(0, 3'd0, 64'h5, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("wrap_cvalid", rob_if.commit_valid_o, 1'b1);
        checkOutput("wrap_cres", rob_if.commit_result_o, 64'h5);
        rob_if.commit_ack_i  = 1'b1;
        rob_if.issue_valid_i = 1'b1;
        applyStimulus();
        rob_if.commit_ack_i = 1'b0;
        checkOutput("wrap_ready_after_ack", rob_if.issue_ready_o, 1'b1);
        checkOutput("wrap_head", rob_if.commit_trans_id_o, 1);
        checkOutput("wrap_id_pending", rob_if.issue_trans_id_o, 0);
        applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        checkOutput("wrap_full_again", rob_if.issue_ready_o, 1'b0);
        checkOutput("wrap_id_next", rob_if.issue_trans_id_o, 1);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("flush1_empty", empty, 1'b1);
        checkOutput("flush1_id", rob_if.issue_trans_id_o, 0);

        // Out-of-order writeback, in-order commit with ack held high.
        rob_if.issue_valid_i = 1'b1;
        repeat (3) applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        checkOutput("ooo_id", rob_if.issue_trans_id_o, 3);
        driveWriteback(1, 3'd2, 64'h22, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("ooo_cvalid_a", rob_if.commit_valid_o, 1'b0);
        driveWriteback(0, 3'd1, 64'h11, 1'b1, 64'h2);
        applyStimulus();
        clearWriteback();
        checkOutput("ooo_cvalid_b", rob_if.commit_valid_o, 1'b0);
        driveWriteback(3, 3'd0, 64'h00, 1'b0, 64'h0);
        rob_if.commit_ack_i = 1'b1;
        applyStimulus();
        clearWriteback();
        checkOutput("ooo_c0_valid", rob_if.commit_valid_o, 1'b1);
        checkOutput("ooo_c0_id", rob_if.commit_trans_id_o, 0);
        checkOutput("ooo_c0_res", rob_if.commit_result_o, 64'h0);
        applyStimulus();
        checkOutput("ooo_c1_valid", rob_if.commit_valid_o, 1'b1);
        checkOutput("ooo_c1_id", rob_if.commit_trans_id_o, 1);
        checkOutput("ooo_c1_res", rob_if.commit_result_o, 64'h11);
        checkOutput("ooo_c1_exc", rob_if.commit_exception_o.valid, 1'b1);
        checkOutput("ooo_c1_cause", rob_if.commit_exception_o.cause, 64'h2);
        applyStimulus();
        checkOutput("ooo_c2_id", rob_if.commit_trans_id_o, 2);
        checkOutput("ooo_c2_res", rob_if.commit_result_o, 64'h22);
        checkOutput("ooo_c2_exc", rob_if.commit_exception_o.valid, 1'b0);
        applyStimulus();
        rob_if.commit_ack_i = 1'b0;
        checkOutput("ooo_drained", empty, 1'b1);
        checkOutput("ooo_cvalid_end", rob_if.commit_valid_o, 1'b0);
        checkOutput("ooo_err", wb_err, 1'b0);

        // Two ports hit ID 3 in the same cycle: port 0 wins.
        checkOutput("conf_id", rob_if.issue_trans_id_o, 3);
        rob_if.issue_valid_i = 1'b1;
        applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        driveWriteback(0, 3'd3, 64'hAA, 1'b0, 64'h0);
        driveWriteback(2, 3'd3, 64'hBB, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("conf_cvalid", rob_if.commit_valid_o, 1'b1);
        checkOutput("conf_res", rob_if.commit_result_o, 64'hAA);
        checkOutput("conf_err", wb_err, 1'b1);
        rob_if.commit_ack_i = 1'b1;
        applyStimulus();
        rob_if.commit_ack_i = 1'b0;
        checkOutput("conf_empty", empty, 1'b1);
        checkOutput("conf_err_sticky", wb_err, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        rob_if.issue_valid_i = 1'b1;
        repeat (2) applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        driveWriteback(1, 3'd4, 64'h44, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("pre_rst_cvalid", rob_if.commit_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        #1 rst_n = 1'b1;

        // Writeback to a FREE entry is ignored but flagged.
        rob_if.issue_valid_i = 1'b1;
        applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        driveWriteback(0, 3'd0, 64'h77, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("free_pre_cvalid", rob_if.commit_valid_o, 1'b1);
        checkOutput("free_pre_err", wb_err, 1'b0);
        driveWriteback(4, 3'd5, 64'h55, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("free_cvalid", rob_if.commit_valid_o, 1'b1);
        checkOutput("free_cres", rob_if.commit_result_o, 64'h77);
        checkOutput("free_id", rob_if.issue_trans_id_o, 1);
        checkOutput("free_err", wb_err, 1'b1);

        // Flush with four in flight (two DONE) beats writeback, ack and issue.
        rob_if.issue_valid_i = 1'b1;
        repeat (3) applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        driveWriteback(2, 3'd1, 64'h99, 1'b0, 64'h0);
        applyStimulus();
        clearWriteback();
        checkOutput("fl_pre_id", rob_if.issue_trans_id_o, 4);
        flush                = 1'b1;
        rob_if.commit_ack_i  = 1'b1;
        rob_if.issue_valid_i = 1'b1;
        driveWriteback(0, 3'd2, 64'h33, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        checkOutput("fl_empty", empty, 1'b1);
        checkOutput("fl_id", rob_if.issue_trans_id_o, 0);
        checkOutput("fl_cvalid", rob_if.commit_valid_o, 1'b0);
        checkOutput("fl_ready", rob_if.issue_ready_o, 1'b1);
        checkOutput("fl_err_kept", wb_err, 1'b1);
        rob_if.issue_valid_i = 1'b1;
        applyStimulus();
        rob_if.issue_valid_i = 1'b0;
        checkOutput("fl_reissue_cvalid", rob_if.commit_valid_o, 1'b0);
        checkOutput("fl_reissue_id", rob_if.issue_trans_id_o, 1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/wb_reorder_buffer.md
Name: wb_reorder_buffer

Overview:
- Receiving end of the execute-stage writeback interface (FLU, load, store, FPU and CVXIF result ports).
- Allocates a transaction ID for each issued instruction and collects out-of-order writebacks.
- Presents results and exceptions to commit strictly in issue order.
- Sits between issue/execute and the commit stage, and stands in for the scoreboard writeback path.

Parameters:
NR_ENTRIES, 8, number of in-flight instructions; power of two, at least 2.
NR_WB_PORTS, 5, number of writeback ports (flu, load, store, fpu, x).
TRANS_ID_BITS, $clog2(NR_ENTRIES), transaction ID width; a localparam, not overridable.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all in-flight entries
issue_valid_i  in  1  request to allocate an entry
issue_ready_o  out  1  an entry is free
issue_trans_id_o  out  TRANS_ID_BITS  ID of the entry that will be allocated (the tail)
wb_valid_i  in  NR_WB_PORTS  per-port writeback valid
wb_trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  per-port target ID
wb_result_i  in  NR_WB_PORTS x riscv::XLEN  per-port result
wb_exception_i  in  NR_WB_PORTS x exception_t  per-port exception (valid bit inside)
commit_valid_o  out  1  head entry is complete
commit_ack_i  in  1  commit consumes the head
commit_trans_id_o  out  TRANS_ID_BITS  head ID
commit_result_o  out  riscv::XLEN  head result
commit_exception_o  out  exception_t  head exception
empty_o  out  1  no entries in flight
wb_err_o  out  1  sticky flag: an illegal writeback was seen

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - all entries FREE; head = tail = 0, with wrap bits 0.
  - issue_ready_o = 1, issue_trans_id_o = 0, empty_o = 1.
  - commit_valid_o = 0, commit_result_o = 0, commit_exception_o = 0, wb_err_o = 0.
- Pointers: head and tail are TRANS_ID_BITS+1 wide; the top bit is the wrap bit.
  - full when the indices are equal and the wrap bits differ.
  - empty when the pointers are fully equal.
- Per-entry state: FREE -> ISSUED (on issue) -> DONE (on writeback) -> FREE (on commit ack).
- Issue:
  - issue_ready_o = !full; it does not depend on commit_ack_i in the same cycle (no bypass).
  - Allocation happens when issue_valid_i && issue_ready_o: the tail entry becomes ISSUED, its result and exception are cleared, and tail increments.
  - issue_trans_id_o is a combinational view of the tail index.
- Writeback:
  - Each valid port whose target entry is ISSUED writes result and exception; the entry becomes DONE at the next clock edge.
  - A writeback to a FREE or DONE entry is ignored and sets wb_err_o.
  - Two or more ports hitting the same ID in one cycle: the lowest-index port wins, the others are dropped, and wb_err_o is set.
  - Different IDs written in the same cycle are all accepted.
- Commit:
  - commit_valid_o = (head entry state == DONE); the commit_* data outputs are combinational from the head entry.
  - commit_ack_i with commit_valid_o frees the head and increments head.
  - commit_ack_i without commit_valid_o is ignored.
  - Minimum latency: writeback in cycle N makes commit_valid_o high in cycle N+1. A writeback does not bypass to commit in the same cycle.
- Simultaneous events:
  - Issue and commit in the same cycle: both take effect; the count is unchanged.
  - When full, a commit in cycle N makes issue_ready_o high in cycle N+1.
  - A writeback to the head and an ack in the same cycle: the ack is ignored, because the head is not yet DONE.
- Flush:
  - Synchronous. All entries become FREE and head = tail = 0.
  - Flush has priority over issue, writeback and ack in the same cycle; none of them take effect.
  - Flush does not clear wb_err_o; only reset clears it.
- Wrap-around: indices wrap modulo NR_ENTRIES and IDs are reused after commit.

Decomposition:
- Shared package ariane_pkg: exception_t; TRANS_ID_BITS, derived from NR_ENTRIES.
- Entry state enum {FREE, ISSUED, DONE}: local to the module.
- Optional sub-module wb_port_select: per-entry priority select over the NR_WB_PORTS ports (lowest-index hit wins, plus a multi-hit flag).

Test Plan:
1. Reset, then issue 8 in consecutive cycles -> IDs 0..7 returned; issue_ready_o=0 after the 8th; empty_o=0.
2. Issue IDs 0,1,2; write back 2 then 1 then 0 on ports 1, 0, 3 with results 0x22, 0x11, 0x00; hold ack=1 -> commit order ID0=0x00, ID1=0x11, ID2=0x22 with no gaps after ID0 is DONE.
3. Full buffer; ack the head and assert issue in the same cycle -> issue is refused that cycle and accepted the next with ID 0 (wrap); wrap bit toggles.
4. Ports 0 and 2 both write ID 3 (ISSUED) with 0xAA and 0xBB -> entry 3 holds 0xAA; wb_err_o=1 and stays set.
5. Writeback to FREE ID 5 -> no state change; commit_valid_o unchanged; wb_err_o=1.
6. Four in flight, two DONE; flush_i together with a writeback and an ack -> next cycle empty_o=1, issue_trans_id_o=0, commit_valid_o=0. Separately, assert rst_ni low mid-operation -> all outputs at reset values asynchronously.
